// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: WIDTH-bit add/subtract computed one nibble per clock
// through a single shared 4-bit ripple adder, LS nibble first. Operands are
// held in right-shifting registers so the active nibble is always bits [3:0];
// the partial result shifts in from the top and is committed to the visible
// result register only on the final nibble edge, so result/flags stay stable
// for the whole duration of the next operation.

// Team 4-bit ripple-carry adder.
module adder_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cf
);
    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

    assign cf = c[4];
endmodule

module nibble_serial_addsub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cf,
    output logic             of,
    output logic             zf
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    // Reject widths the nibble schedule cannot cover.
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_addsub: WIDTH must be a multiple of 4 and >= 8");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] opa_q, opb_q, acc_q, result_q;
    logic             carry_q, busy_q, done_q, cf_q, of_q, zf_q;
    logic [CW-1:0]    cnt_q;

    logic [3:0]       add_s;
    logic             add_cf;
    logic [WIDTH-1:0] acc_d;
    logic             last_nib;

    // The one shared nibble adder; current slice always sits in bits [3:0].
    adder_4 u_add (
        .a   (opa_q[3:0]),
        .b   (opb_q[3:0]),
        .cin (carry_q),
        .s   (add_s),
        .cf  (add_cf)
    );

    // Next partial result: new nibble enters at the top, older ones move down.
    always_comb begin
        acc_d    = {add_s, acc_q[WIDTH-1:4]};
        last_nib = (cnt_q == CW'(NIB - 1));
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cf_q     <= 1'b0;
            of_q     <= 1'b0;
            zf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= sub ? ~b : b;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    opa_q   <= opa_q >> 4;
                    opb_q   <= opb_q >> 4;
                    acc_q   <= acc_d;
                    carry_q <= add_cf;
                    cnt_q   <= cnt_q + CW'(1);
                    if (last_nib) begin
                        // opa/opb [3] are the operand sign bits on this cycle.
                        result_q <= acc_d;
                        cf_q     <= add_cf;
                        of_q     <= (opa_q[3] == opb_q[3]) && (add_s[3] != opa_q[3]);
                        zf_q     <= (acc_d == '0);
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cf     = cf_q;
    assign of     = of_q;
    assign zf     = zf_q;
endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Bench for nibble_serial_addsub: directed table at WIDTH=16, handshake corner
// sequences, then concurrent back-to-back random runs at WIDTH=8/16/32.
module tb_nibble_serial_addsub;
    logic clk, rst_n;
    int   cyc = 0;
    int   ntot = 0, nbad = 0;

    logic        st8, sb8, bz8, dn8, cf8, of8, zf8;
    logic [7:0]  a8, b8, r8;
    logic        st16, sb16, bz16, dn16, cf16, of16, zf16;
    logic [15:0] a16, b16, r16;
    logic        st32, sb32, bz32, dn32, cf32, of32, zf32;
    logic [31:0] a32, b32, r32;

    nibble_serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(b8),
        .busy(bz8), .done(dn8), .result(r8), .cf(cf8), .of(of8), .zf(zf8));
    nibble_serial_addsub #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .sub(sb16), .a(a16), .b(b16),
        .busy(bz16), .done(dn16), .result(r16), .cf(cf16), .of(of16), .zf(zf16));
    nibble_serial_addsub #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .sub(sb32), .a(a32), .b(b32),
        .busy(bz32), .done(dn32), .result(r32), .cf(cf32), .of(of32), .zf(zf32));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] r;
        logic        c, o, z;
    } res_t;

    typedef struct {
        string       nm;
        logic        sub;
        logic [15:0] a, b, res;
        logic        cf, of, zf;
    } vec_t;

    // Plain integer reference: a + (sub ? ~b : b) + sub, truncated to w bits.
    function automatic res_t model(int w, logic [31:0] a, logic [31:0] b, logic s);
        logic [32:0] m, bb, sum;
        res_t x;
        m     = (33'd1 << w) - 33'd1;
        bb    = (s ? ~{1'b0, b} : {1'b0, b}) & m;
        sum   = ({1'b0, a} & m) + bb + {32'd0, s};
        x.r   = sum[31:0] & m[31:0];
        x.c   = sum[w];
        x.o   = (a[w-1] == bb[w-1]) && (x.r[w-1] != a[w-1]);
        x.z   = (x.r == 32'd0);
        return x;
    endfunction

    task automatic chk(string nm, logic [32:0] act, logic [32:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One 16-bit operation from a negedge; reports done position/count and busy length.
    task automatic run16(input logic s, input logic [15:0] a, input logic [15:0] b,
                         output int dcyc, output int dcnt, output int bcnt);
        sb16 = s; a16 = a; b16 = b; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        dcyc = 0; dcnt = 0; bcnt = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bz16) bcnt++;
            if (dn16) begin
                dcnt++;
                if (dcyc == 0) dcyc = k;
            end
        end
    endtask

    vec_t vt[6];
    int   dcyc, dcnt, bcnt;
    int   done_seen;
    res_t e;

    initial begin
        vt[0] = '{"add_1234_0fcd", 1'b0, 16'h1234, 16'h0FCD, 16'h2201, 1'b0, 1'b0, 1'b0};
        vt[1] = '{"add_ffff_0001", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{"add_7fff_0001", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{"sub_0005_0007", 1'b1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{"sub_8000_0001", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{"sub_1234_1234", 1'b1, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst_n = 1'b0;
        st8 = 0; sb8 = 0; a8 = '0; b8 = '0;
        st16 = 0; sb16 = 0; a16 = '0; b16 = '0;
        st32 = 0; sb32 = 0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bz16, 0);
        chk("rst_done", dn16, 0);
        chk("rst_result", r16, 0);
        chk("rst_flags", {cf16, of16, zf16}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        foreach (vt[i]) begin
            run16(vt[i].sub, vt[i].a, vt[i].b, dcyc, dcnt, bcnt);
            chk({vt[i].nm, "_done_at"}, dcyc, 5);
            chk({vt[i].nm, "_done_cnt"}, dcnt, 1);
            chk({vt[i].nm, "_busy_len"}, bcnt, 5);
            chk({vt[i].nm, "_res"}, r16, vt[i].res);
            chk({vt[i].nm, "_cf"}, cf16, vt[i].cf);
            chk({vt[i].nm, "_of"}, of16, vt[i].of);
            chk({vt[i].nm, "_zf"}, zf16, vt[i].zf);
        end

        // start while busy (RUN and DONE) is ignored; operand changes mid-run too.
        sb16 = 0; a16 = 16'h1111; b16 = 16'h2222; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        done_seen = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (dn16) done_seen++;
            if (k == 2) begin a16 = 16'hFFFF; b16 = 16'h0001; sb16 = 1; st16 = 1; end
            if (k == 3) begin st16 = 0; a16 = 16'h0F0F; b16 = 16'h0F0F; end
            if (k == 5) begin
                chk("ign_done_at5", dn16, 1);
                a16 = 16'h4444; st16 = 1;
            end
            if (k == 6) begin
                st16 = 0;
                chk("ign_busy_drop", bz16, 0);
            end
        end
        chk("ign_done_cnt", done_seen, 1);
        chk("ign_res", r16, 16'h3333);
        chk("ign_cf", cf16, 0);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        sb16 = 0; a16 = 16'hAAAA; b16 = 16'h5555; st16 = 1'b1;
        @(posedge clk);
        #1 st16 = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", bz16, 0);
        chk("arst_result", r16, 0);
        chk("arst_flags", {cf16, of16, zf16}, 0);
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dn16) done_seen++;
            if (k == 1) rst_n = 1'b1;
        end
        chk("arst_no_done", done_seen, 0);
        run16(0, 16'h0001, 16'h0001, dcyc, dcnt, bcnt);
        chk("arst_after_res", r16, 16'h0002);
        chk("arst_after_done", dcnt, 1);

        // Back-to-back with start held high, all three widths concurrently.
        @(negedge clk);
        fork
            begin : bb8
                res_t q[$]; res_t x;
                int iss = 0, got = 0, last = -1, guard = 0;
                while (!(got == 1000 && !bz8) && guard < 20000) begin
                    @(negedge clk); guard++;
                    if (dn8) begin
                        if (q.size() == 0) chk("b8_spurious_done", 1, 0);
                        else begin
                            x = q.pop_front();
                            chk("b8_res", r8, x.r[7:0]);
                            chk("b8_flags", {cf8, of8, zf8}, {x.c, x.o, x.z});
                            if (last >= 0) chk("b8_period", cyc - last, 4);
                            last = cyc; got++;
                        end
                    end
                    if (!bz8) begin
                        if (iss < 1000) begin
                            a8 = 8'($urandom); b8 = 8'($urandom);
                            sb8 = 1'($urandom_range(0, 1)); st8 = 1'b1;
                            q.push_back(model(8, {24'd0, a8}, {24'd0, b8}, sb8));
                            iss++;
                        end else st8 = 1'b0;
                    end
                end
                if (guard >= 20000) chk("b8_timeout", 1, 0);
                st8 = 1'b0;
            end
            begin : bb16
                res_t q[$]; res_t x;
                int iss = 0, got = 0, last = -1, guard = 0;
                while (!(got == 1000 && !bz16) && guard < 20000) begin
                    @(negedge clk); guard++;
                    if (dn16) begin
                        if (q.size() == 0) chk("b16_spurious_done", 1, 0);
                        else begin
                            x = q.pop_front();
                            chk("b16_res", r16, x.r[15:0]);
                            chk("b16_flags", {cf16, of16, zf16}, {x.c, x.o, x.z});
                            if (last >= 0) chk("b16_period", cyc - last, 6);
                            last = cyc; got++;
                        end
                    end
                    if (!bz16) begin
                        if (iss < 1000) begin
                            a16 = 16'($urandom); b16 = 16'($urandom);
                            sb16 = 1'($urandom_range(0, 1)); st16 = 1'b1;
                            q.push_back(model(16, {16'd0, a16}, {16'd0, b16}, sb16));
                            iss++;
                        end else st16 = 1'b0;
                    end
                end
                if (guard >= 20000) chk("b16_timeout", 1, 0);
                st16 = 1'b0;
            end
            begin : bb32
                res_t q[$]; res_t x;
                int iss = 0, got = 0, last = -1, guard = 0;
                while (!(got == 1000 && !bz32) && guard < 20000) begin
                    @(negedge clk); guard++;
                    if (dn32) begin
                        if (q.size() == 0) chk("b32_spurious_done", 1, 0);
                        else begin
                            x = q.pop_front();
                            chk("b32_res", r32, x.r);
                            chk("b32_flags", {cf32, of32, zf32}, {x.c, x.o, x.z});
                            if (last >= 0) chk("b32_period", cyc - last, 10);
                            last = cyc; got++;
                        end
                    end
                    if (!bz32) begin
                        if (iss < 1000) begin
                            a32 = $urandom; b32 = $urandom;
                            sb32 = 1'($urandom_range(0, 1)); st32 = 1'b1;
                            q.push_back(model(32, a32, b32, sb32));
                            iss++;
                        end else st32 = 1'b0;
                    end
                end
                if (guard >= 20000) chk("b32_timeout", 1, 0);
                st32 = 1'b0;
            end
        join

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end
endmodule
